// File: rtl/grid_pkg.sv
// Shared constants and types for the Tetris grid RAM arbiter:
// grid geometry, cell codes, clear-FSM states and read-owner tags.
package grid_pkg;

    localparam int GRID_COLS  = 12;
    localparam int GRID_ROWS  = 20;
    localparam int GRID_CELLS = GRID_COLS * GRID_ROWS;

    localparam logic [7:0] LAST_ADDR = 8'(GRID_CELLS - 1);

    typedef enum logic [7:0] {
        CELL_AIR    = 8'd0,
        CELL_I      = 8'd1,
        CELL_O      = 8'd2,
        CELL_T      = 8'd3,
        CELL_S      = 8'd4,
        CELL_Z      = 8'd5,
        CELL_J      = 8'd6,
        CELL_L      = 8'd7,
        CELL_BORDER = 8'd8
    } cell_t;

    localparam logic [7:0] AIR_CODE    = CELL_AIR;
    localparam logic [7:0] BORDER_CODE = CELL_BORDER;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR_WAIT,
        ST_CLEAR,
        ST_DONE
    } clr_state_t;

    typedef enum logic {
        OWN_VID,
        OWN_GAME
    } owner_t;

endpackage

// File: rtl/grid_clear_seq.sv
// Clear sequencer: walks addresses 0..GRID_CELLS-1 with row/col counters
// running alongside, and produces the border/air pattern for each cell.
module grid_clear_seq
    import grid_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    output logic [7:0] addr,
    output logic [7:0] wdata,
    output logic       last
);

    logic [3:0] col;
    logic [4:0] row;

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr <= '0;
            col  <= '0;
            row  <= '0;
        end else if (step) begin
            if (last) begin
                addr <= '0;
                col  <= '0;
                row  <= '0;
            end else begin
                addr <= addr + 8'd1;
                if (col == 4'(GRID_COLS - 1)) begin
                    col <= '0;
                    row <= row + 5'd1;
                end else begin
                    col <= col + 4'd1;
                end
            end
        end
    end

    assign last  = (addr == LAST_ADDR);
    assign wdata = (col == 4'd0 || col == 4'(GRID_COLS - 1) || row == 5'(GRID_ROWS - 1))
                   ? BORDER_CODE : AIR_CODE;

endmodule

// File: rtl/grid_mem_arbiter.sv
// Time-slot arbiter for the single-port grid RAM: video reads in even slots,
// game read/write and the clear sequencer in odd slots or during blanking.
module grid_mem_arbiter
    import grid_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       px_en,
    input  logic [7:0] vid_addr,
    output logic [7:0] vid_data,
    input  logic       game_req,
    input  logic       game_we,
    input  logic [7:0] game_addr,
    input  logic [7:0] game_wdata,
    output logic       game_ack,
    output logic [7:0] game_rdata,
    input  logic       clear_start,
    output logic       clear_busy,
    output logic       clear_done,
    output logic [7:0] mem_addr,
    output logic       mem_we,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata
);

    clr_state_t state, state_nxt;
    owner_t     rd_owner;
    logic       slot;
    logic       rd_pend, rd_oob, rd_wr;
    logic       eligible, vid_issue, game_issue, clr_step, game_inflight;
    logic [7:0] clr_addr, clr_wdata;
    logic       clr_last;

    grid_clear_seq u_clear_seq (
        .clk   (clk),
        .reset (reset),
        .step  (clr_step),
        .addr  (clr_addr),
        .wdata (clr_wdata),
        .last  (clr_last)
    );

    assign game_inflight = rd_pend && (rd_owner == OWN_GAME);
    assign eligible      = slot || !px_en;
    assign vid_issue     = !slot && px_en;

    // NOTE: every combinational output is defaulted first so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        game_issue = 1'b0;
        clr_step   = 1'b0;
        clear_busy = 1'b0;
        clear_done = 1'b0;
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_wdata  = '0;

        case (state)
            ST_IDLE: begin
                if (clear_start)
                    state_nxt = ST_CLEAR_WAIT;
                else if (eligible && game_req && !game_inflight && !game_ack)
                    game_issue = 1'b1;
            end
            ST_CLEAR_WAIT: begin
                clear_busy = 1'b1;
                if (!game_inflight)
                    state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                clear_busy = 1'b1;
                if (eligible) begin
                    clr_step = 1'b1;
                    if (clr_last)
                        state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                clear_done = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (vid_issue) begin
            mem_addr = vid_addr;
        end else if (game_issue) begin
            mem_addr  = game_addr;
            mem_we    = game_we && (game_addr <= LAST_ADDR);
            mem_wdata = game_wdata;
        end else if (clr_step) begin
            mem_addr  = clr_addr;
            mem_we    = 1'b1;
            mem_wdata = clr_wdata;
        end

        // RAM controls are held off during reset so an aborted access cannot write.
        if (!reset) begin
            mem_addr  = '0;
            mem_we    = 1'b0;
            mem_wdata = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            slot       <= 1'b0;
            rd_pend    <= 1'b0;
            rd_owner   <= OWN_VID;
            rd_oob     <= 1'b0;
            rd_wr      <= 1'b0;
            vid_data   <= '0;
            game_ack   <= 1'b0;
            game_rdata <= '0;
        end else begin
            state    <= state_nxt;
            slot     <= ~slot;
            rd_pend  <= vid_issue || game_issue;
            rd_owner <= game_issue ? OWN_GAME : OWN_VID;
            rd_oob   <= game_issue ? (game_addr > LAST_ADDR) : (vid_addr > LAST_ADDR);
            rd_wr    <= game_issue && game_we;
            game_ack <= game_inflight;
            // The owner tag steers the returning RAM word; out-of-range reads return 0.
            if (rd_pend && rd_owner == OWN_VID)
                vid_data <= rd_oob ? 8'd0 : mem_rdata;
            if (game_inflight && !rd_wr)
                game_rdata <= rd_oob ? 8'd0 : mem_rdata;
        end
    end

endmodule
